// File: rtl/rs_enc_lfsr_pkg.sv
// Shared GF(2^10) arithmetic and RS(128,116) code constants used by both encoder and decoder.
// The generator polynomial is derived here from the field definition so both sides agree by construction.
package rs_enc_lfsr_pkg;

    localparam int PREST = 10;
    localparam int N     = 128;
    localparam int K     = 116;
    localparam int T     = (N - K) / 2;
    localparam int NPAR  = 2 * T;

    localparam logic [PREST:0] PRIM_POL = 11'h409;

    typedef logic [PREST-1:0] gf_sym_t;
    typedef logic [NPAR-1:0][PREST-1:0] sym_vec_t;

    typedef enum logic {
        ST_DATA,
        ST_PARITY
    } enc_state_t;

    typedef struct packed {
        gf_sym_t dat;
        logic    par;
        logic    last;
    } out_beat_t;

    // Shift-and-add product, reducing by the primitive polynomial on every shift.
    function automatic gf_sym_t multgf(input gf_sym_t a, input gf_sym_t b);
        gf_sym_t p;
        p = '0;
        for (int i = PREST - 1; i >= 0; i--) begin
            if (p[PREST-1])
                p = {p[PREST-2:0], 1'b0} ^ PRIM_POL[PREST-1:0];
            else
                p = {p[PREST-2:0], 1'b0};
            if (b[i])
                p = p ^ a;
        end
        return p;
    endfunction

    // g(x) = prod_{i=1..2T} (x + alpha^i); the monic x^2T term is implicit.
    function automatic sym_vec_t gen_poly();
        logic [NPAR:0][PREST-1:0] g;
        gf_sym_t                  root;
        g    = '0;
        g[0] = gf_sym_t'(1);
        root = gf_sym_t'(1);
        for (int i = 1; i <= NPAR; i++) begin
            root = multgf(root, gf_sym_t'(2));
            for (int j = NPAR; j >= 1; j--)
                g[j] = g[j-1] ^ multgf(g[j], root);
            g[0] = multgf(g[0], root);
        end
        return g[NPAR-1:0];
    endfunction

    localparam sym_vec_t G = gen_poly();

endpackage

// File: rtl/rs_enc_out_reg.sv
// One-deep valid/ready output stage carrying a codeword symbol and its parity/last flags.
// Loads while empty or draining, so a full-rate stream passes with one cycle of latency.
module rs_enc_out_reg
    import rs_enc_lfsr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_vld,
    input  out_beat_t        ld_beat,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [PREST-1:0] m_data,
    output logic             m_parity,
    output logic             m_last
);

    logic      vld_q, vld_d;
    out_beat_t beat_q, beat_d;

    always_comb begin
        vld_d  = vld_q;
        beat_d = beat_q;
        if (ld_vld) begin
            vld_d  = 1'b1;
            beat_d = ld_beat;
        end else if (m_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            beat_q <= '0;
        end else begin
            vld_q  <= vld_d;
            beat_q <= beat_d;
        end
    end

    assign m_valid  = vld_q;
    assign m_data   = beat_q.dat;
    assign m_parity = beat_q.par;
    assign m_last   = beat_q.last;

endmodule

// File: rtl/rs_enc_lfsr.sv
// Systematic RS(128,116) encoder over GF(2^10): forwards 116 message symbols, then appends 12 LFSR parity symbols.
// One cycle input-to-output latency; input stalls during parity and whenever the output register is held.
module rs_enc_lfsr
    import rs_enc_lfsr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PREST-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PREST-1:0] m_data,
    output logic             m_parity,
    output logic             m_last
);

    localparam logic [6:0] DATA_LAST = 7'(K - 1);
    localparam logic [6:0] PAR_LAST  = 7'(NPAR - 1);

    enc_state_t state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    sym_vec_t   r_q, r_d;
    logic       out_free, in_fire, par_load, ld_vld;
    out_beat_t  ld_beat;
    gf_sym_t    fb;

    assign out_free = ~m_valid | m_ready;
    assign s_ready  = ~rst & (state_q == ST_DATA) & out_free;
    assign in_fire  = s_valid & s_ready;
    assign par_load = (state_q == ST_PARITY) & out_free;
    assign fb       = s_data ^ r_q[NPAR-1];

    // cnt_q indexes message symbols in DATA and parity symbols in PARITY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        ld_vld  = 1'b0;
        ld_beat = '0;
        if (in_fire) begin
            ld_vld      = 1'b1;
            ld_beat.dat = s_data;
            r_d[0]      = multgf(fb, G[0]);
            for (int i = 1; i < NPAR; i++)
                r_d[i] = r_q[i-1] ^ multgf(fb, G[i]);
            if (cnt_q == DATA_LAST) begin
                state_d = ST_PARITY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 7'd1;
            end
        end else if (par_load) begin
            ld_vld       = 1'b1;
            ld_beat.dat  = r_q[NPAR-1];
            ld_beat.par  = 1'b1;
            ld_beat.last = (cnt_q == PAR_LAST);
            // Shifting zeros in leaves the LFSR clear for the next codeword.
            r_d[0] = '0;
            for (int i = 1; i < NPAR; i++)
                r_d[i] = r_q[i-1];
            if (cnt_q == PAR_LAST) begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
        end
    end

    rs_enc_out_reg u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .ld_vld   (ld_vld),
        .ld_beat  (ld_beat),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_parity (m_parity),
        .m_last   (m_last)
    );

endmodule

// File: tb/tb_rs_enc_lfsr.sv
// Directed bench for rs_enc_lfsr: golden parity by polynomial long division with log/antilog GF tables.
module tb_rs_enc_lfsr;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [9:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [9:0] m_data;
    logic       m_parity;
    logic       m_last;

    always #5 clk = ~clk;

    rs_enc_lfsr dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_parity (m_parity),
        .m_last   (m_last)
    );

    int total = 0;
    int bad   = 0;
    int alog [0:1022];
    int lg   [0:1023];
    int gen  [0:12];
    int gold [0:127];
    int inq [$];
    int dq  [$];
    int pq  [$];
    int lq  [$];
    int in_idx;
    bit last_srdy;

    task automatic chk(input string tag, input int idx, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=0x%0h expected=0x%0h", tag, idx, obs, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return alog[(lg[a] + lg[b]) % 1023];
    endfunction

    task automatic build_tables();
        int v;
        alog[0] = 1;
        lg[1]   = 0;
        lg[0]   = 0;
        for (int i = 1; i < 1023; i++) begin
            v = alog[i-1] << 1;
            if ((v & 32'h400) != 0) v = v ^ 32'h409;
            alog[i] = v;
            lg[v]   = i;
        end
        for (int j = 0; j <= 12; j++) gen[j] = 0;
        gen[0] = 1;
        for (int i = 1; i <= 12; i++) begin
            for (int j = 12; j >= 1; j--) gen[j] = gen[j-1] ^ gmul(gen[j], alog[i]);
            gen[0] = gmul(gen[0], alog[i]);
        end
    endtask

    // Codeword = message followed by remainder of m(x)*x^12 divided by g(x).
    task automatic make_gold(input int off);
        int c;
        for (int k = 0; k < 128; k++) gold[k] = (k < 116) ? inq[off+k] : 0;
        for (int i = 0; i < 116; i++) begin
            c = gold[i];
            for (int j = 0; j <= 12; j++) gold[i+j] = gold[i+j] ^ gmul(c, gen[12-j]);
        end
        for (int k = 0; k < 116; k++) gold[k] = inq[off+k];
    endtask

    task automatic tick(input bit vld_en, input bit rdy_en, output bit ix, output bit ox);
        s_valid = vld_en && (in_idx < inq.size());
        s_data  = s_valid ? 10'(inq[in_idx]) : 10'h2AA;
        m_ready = rdy_en;
        #1;
        last_srdy = s_ready;
        ix = s_valid && s_ready;
        ox = m_valid && m_ready;
        if (ix) in_idx++;
        if (ox) begin
            dq.push_back(int'(m_data));
            pq.push_back(int'(m_parity));
            lq.push_back(int'(m_last));
        end
        @(negedge clk);
    endtask

    task automatic run_until(input int n_out, input int vld_pct, input int rdy_pct,
                             input int budget, input string tag);
        int cyc;
        bit ix, ox;
        cyc = 0;
        while (dq.size() < n_out && cyc < budget) begin
            tick(int'($urandom_range(99)) < vld_pct, int'($urandom_range(99)) < rdy_pct, ix, ox);
            cyc++;
        end
        chk({tag, "_timeout"}, cyc, int'(dq.size() >= n_out), 1);
    endtask

    task automatic verify_cw(input string tag, input int msg_off, input int out_off, input int nsym);
        int s;
        if (dq.size() < out_off + nsym) return;
        make_gold(msg_off);
        for (int k = 0; k < nsym; k++) begin
            chk({tag, "_dat"},  k, dq[out_off+k], gold[k]);
            chk({tag, "_par"},  k, pq[out_off+k], int'(k >= 116));
            chk({tag, "_last"}, k, lq[out_off+k], int'(k == 127));
        end
        if (nsym == 128) begin
            for (int i = 1; i <= 12; i++) begin
                s = 0;
                for (int k = 0; k < 128; k++) s = gmul(s, alog[i]) ^ dq[out_off+k];
                chk({tag, "_syndrome"}, i, s, 0);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_m_valid"},  0, int'(m_valid),  0);
        chk({tag, "_m_data"},   0, int'(m_data),   0);
        chk({tag, "_m_parity"}, 0, int'(m_parity), 0);
        chk({tag, "_m_last"},   0, int'(m_last),   0);
        chk({tag, "_s_ready"},  0, int'(s_ready),  0);
    endtask

    task automatic clear_q();
        inq.delete();
        dq.delete();
        pq.delete();
        lq.delete();
        in_idx = 0;
    endtask

    task automatic push_random_msg();
        for (int k = 0; k < 116; k++) inq.push_back(int'($urandom_range(1023)));
    endtask

    initial begin
        int  held, c, first_in, last_out, lowcnt;
        bit  ix, ox;
        build_tables();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        in_idx  = 0;

        // Reset state and release.
        @(negedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_s_ready", 0, int'(s_ready), 1);
        chk("post_reset_m_valid", 0, int'(m_valid), 0);

        // All-zero message: codeword is all zero, flags at 116..127 and 127.
        clear_q();
        for (int k = 0; k < 116; k++) inq.push_back(0);
        tick(1'b1, 1'b1, ix, ox);
        chk("zero_first_xfer", 0, int'(ix), 1);
        chk("zero_first_vld", 0, int'(m_valid), 1);
        run_until(128, 100, 100, 400, "zero");
        for (int k = 0; k < 128 && k < dq.size(); k++) chk("zero_dat_const", k, dq[k], 0);
        verify_cw("zero", 0, 0, 128);

        // Single trailing 1: parity is g(x) below the monic term, highest degree first.
        clear_q();
        for (int k = 0; k < 115; k++) inq.push_back(0);
        inq.push_back(1);
        run_until(128, 100, 100, 400, "unit");
        verify_cw("unit", 0, 0, 128);
        for (int k = 0; k < 12 && 116 + k < dq.size(); k++) chk("unit_gen", k, dq[116+k], gen[11-k]);

        // Random messages with random valid/ready.
        clear_q();
        for (int m = 0; m < 100; m++) push_random_msg();
        run_until(100 * 128, 50, 50, 60000, "rand");
        chk("rand_in_count", 0, in_idx, 100 * 116);
        chk("rand_out_count", 0, dq.size(), 100 * 128);
        for (int m = 0; m < 100; m++) verify_cw("rand", m * 116, m * 128, 128);

        // Backpressure held for 20 cycles while a parity symbol sits in the output register.
        clear_q();
        push_random_msg();
        run_until(119, 100, 100, 300, "bp_pre");
        held = int'(m_data);
        chk("bp_vld", 0, int'(m_valid), 1);
        chk("bp_par", 0, int'(m_parity), 1);
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, 1'b0, ix, ox);
            chk("bp_hold_dat", k, int'(m_data), held);
            chk("bp_hold_vld", k, int'(m_valid), 1);
            chk("bp_s_ready", k, int'(s_ready), 0);
        end
        run_until(128, 100, 100, 100, "bp_post");
        verify_cw("bp", 0, 0, 128);

        // Reset at data symbol 50, then again during parity symbol 5.
        clear_q();
        push_random_msg();
        c = 0;
        while (in_idx < 50 && c < 200) begin
            tick(1'b1, 1'b1, ix, ox);
            c++;
        end
        chk("rst1_reach", 0, in_idx, 50);
        rst     = 1'b1;
        s_valid = 1'b0;
        #1;
        check_reset("rst1");
        @(negedge clk);
        check_reset("rst1_hold");
        rst = 1'b0;
        clear_q();
        push_random_msg();
        run_until(121, 100, 100, 300, "rst2_pre");
        chk("rst2_at_par5", 0, int'(m_parity), 1);
        rst     = 1'b1;
        s_valid = 1'b0;
        #1;
        check_reset("rst2");
        @(negedge clk);
        rst = 1'b0;
        verify_cw("rst_partial", 0, 0, 121);
        clear_q();
        push_random_msg();
        run_until(128, 100, 100, 300, "rst_after");
        verify_cw("rst_after", 0, 0, 128);

        // Back-to-back codewords at full rate.
        clear_q();
        push_random_msg();
        push_random_msg();
        c = 0;
        first_in = -1;
        last_out = -1;
        lowcnt = 0;
        while (dq.size() < 256 && c < 600) begin
            tick(1'b1, 1'b1, ix, ox);
            if (first_in < 0 && ix) first_in = c;
            if (first_in >= 0 && !last_srdy) lowcnt++;
            if (ox) last_out = c;
            c++;
        end
        chk("b2b_out_count", 0, dq.size(), 256);
        chk("b2b_span", 0, last_out - first_in + 1, 257);
        chk("b2b_s_ready_low", 0, lowcnt, 24);
        verify_cw("b2b0", 0, 0, 128);
        verify_cw("b2b1", 116, 128, 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
